// File: rtl/tq_reorder_pkg.sv
// Shared types and the output-order address map for the 32-point coefficient reorder buffer.
package tq_reorder_pkg;

    localparam int DW = 28;
    localparam int N  = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Bank slot holding natural index k; the butterfly interleave is a 1-bit rotate of k.
    function automatic logic [AW-1:0] depremuat_addr(
        input logic [AW-1:0] k,
        input logic          en,
        input logic          inv
    );
        logic [AW-1:0] a;
        if (!en)
            a = k;
        else if (!inv)
            a = {k[3:0], k[4]};
        else
            a = {k[0], k[4:1]};
        return a;
    endfunction

endpackage

// File: rtl/reorder_bank_32.sv
// One 32-entry coefficient bank with its latched reorder mode and fill state.
module reorder_bank_32
    import tq_reorder_pkg::*;
#(
    parameter int DW = tq_reorder_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_mode_en,
    input  logic          wr_mode_inv,
    input  logic          rd_done,
    input  logic [AW-1:0] rd_k,
    output bank_state_e   state,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [N];
    logic          mode_en;
    logic          mode_inv;

    // Storage is deliberately not reset; state alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            mode_en  <= 1'b0;
            mode_inv <= 1'b0;
        end else begin
            if (wr_en && wr_addr == '0) begin
                mode_en  <= wr_mode_en;
                mode_inv <= wr_mode_inv;
            end
            // A bank is never written while FULL and never drained unless FULL.
            if (wr_en)
                state <= (wr_addr == AW'(N - 1)) ? FULL : FILLING;
            else if (rd_done)
                state <= EMPTY;
        end
    end

    assign rd_data = mem[depremuat_addr(rd_k, mode_en, mode_inv)];

endmodule

// File: rtl/depremuat_32_buf.sv
// Ping-pong reorder buffer: butterfly-order coefficients in, natural-order coefficients out.
module depremuat_32_buf
    import tq_reorder_pkg::*;
#(
    parameter int DW = tq_reorder_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic          i_enable,
    input  logic          i_inverse,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [AW-1:0] o_idx,
    output logic          o_last
);

    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic          wr_fire;
    logic          rd_fire;
    logic [1:0]    wr_en;
    logic [1:0]    rd_done;
    bank_state_e   state   [2];
    logic [DW-1:0] rd_data [2];

    // Handshake outputs come from registered bank state only, so no o_ready->i_ready path.
    assign i_ready = (state[wr_bank] != FULL);
    assign o_valid = (state[rd_bank] == FULL);
    assign o_data  = rd_data[rd_bank];
    assign o_idx   = rd_cnt;
    assign o_last  = o_valid && (rd_cnt == AW'(N - 1));
    assign wr_fire = i_valid && i_ready;
    assign rd_fire = o_valid && o_ready;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign wr_en[g]   = wr_fire && (wr_bank == 1'(g));
        assign rd_done[g] = rd_fire && o_last && (rd_bank == 1'(g));

        reorder_bank_32 #(.DW(DW)) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (wr_en[g]),
            .wr_addr     (wr_cnt),
            .wr_data     (i_data),
            .wr_mode_en  (i_enable),
            .wr_mode_inv (i_inverse),
            .rd_done     (rd_done[g]),
            .rd_k        (rd_cnt),
            .state       (state[g]),
            .rd_data     (rd_data[g])
        );
    end

    // Counters wrap naturally at 32; bank pointers flip on each block boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == AW'(N - 1))
                    wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (o_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

endmodule
